// File: rtl/sprite_compositor.sv
// Two-stage VGA pixel compositor: fixed-priority solid sprites over background RGB,
// with per-sprite hit-flash counters and per-frame sprite-overlap detection.
module sprite_compositor #(
    parameter int NUM_SPRITES  = 2,
    parameter int SPRITE_W     = 120,
    parameter int SPRITE_H     = 180,
    parameter int COORD_W      = 10,
    parameter int COLOR_W      = 4,
    parameter int FLASH_FRAMES = 8,
    parameter int FLASH_CW     = 4
) (
    input  logic                             vga_clk,
    input  logic                             reset_n,
    input  logic                             frame_start,
    input  logic [COORD_W-1:0]               DrawX,
    input  logic [COORD_W-1:0]               DrawY,
    input  logic                             blank,
    input  logic [NUM_SPRITES*COORD_W-1:0]   sprite_x,
    input  logic [NUM_SPRITES*COORD_W-1:0]   sprite_y,
    input  logic [NUM_SPRITES-1:0]           sprite_en,
    input  logic [NUM_SPRITES*3*COLOR_W-1:0] sprite_rgb,
    input  logic [NUM_SPRITES-1:0]           hit,
    input  logic [COLOR_W-1:0]               bg_red,
    input  logic [COLOR_W-1:0]               bg_green,
    input  logic [COLOR_W-1:0]               bg_blue,
    output logic [COLOR_W-1:0]               Red,
    output logic [COLOR_W-1:0]               Green,
    output logic [COLOR_W-1:0]               Blue,
    output logic                             collide_frame,
    output logic [NUM_SPRITES-1:0]           flashing
);

    localparam int PIX_W = 3 * COLOR_W;
    localparam logic [COORD_W:0]    SW_L       = (COORD_W+1)'(SPRITE_W);
    localparam logic [COORD_W:0]    SH_L       = (COORD_W+1)'(SPRITE_H);
    localparam logic [FLASH_CW-1:0] FLASH_LOAD = FLASH_CW'(FLASH_FRAMES);

    logic [NUM_SPRITES-1:0]                on_d;
    logic [NUM_SPRITES-1:0][FLASH_CW-1:0]  flash_q, flash_d;
    logic [NUM_SPRITES-1:0]                flashing_q;

    logic [NUM_SPRITES-1:0]                on_p1_q;
    logic [NUM_SPRITES-1:0]                white_p1_q;
    logic [NUM_SPRITES-1:0][PIX_W-1:0]     rgb_p1_q;
    logic [PIX_W-1:0]                      bg_p1_q;
    logic                                  blank_p1_q;

    logic [PIX_W-1:0]                      pix_d, pix_p2_q;
    logic                                  ov_p1;
    logic                                  acc_q, acc_d;
    logic                                  collide_q, collide_d;

    // Differences are only taken when DrawX/DrawY >= origin, so a sprite never wraps past 0.
    always_comb begin
        on_d = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            on_d[i] = sprite_en[i]
                && (DrawX >= sprite_x[i*COORD_W +: COORD_W])
                && ({1'b0, DrawX - sprite_x[i*COORD_W +: COORD_W]} < SW_L)
                && (DrawY >= sprite_y[i*COORD_W +: COORD_W])
                && ({1'b0, DrawY - sprite_y[i*COORD_W +: COORD_W]} < SH_L);
        end
    end

    always_comb begin
        flash_d = flash_q;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (hit[i]) begin
                flash_d[i] = FLASH_LOAD;
            end else if (frame_start && (flash_q[i] != '0)) begin
                flash_d[i] = flash_q[i] - 1'b1;
            end
        end
    end

    // Walk from lowest priority upward so the lowest-index sprite wins.
    always_comb begin
        pix_d = '0;
        if (blank_p1_q) begin
            pix_d = bg_p1_q;
            for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
                if (on_p1_q[i]) begin
                    pix_d = white_p1_q[i] ? {PIX_W{1'b1}} : rgb_p1_q[i];
                end
            end
        end
    end

    always_comb begin
        ov_p1     = blank_p1_q && ($countones(on_p1_q) >= 2);
        acc_d     = acc_q | ov_p1;
        collide_d = collide_q;
        if (frame_start) begin
            collide_d = acc_q;
            acc_d     = ov_p1;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            flash_q    <= '0;
            flashing_q <= '0;
            on_p1_q    <= '0;
            white_p1_q <= '0;
            rgb_p1_q   <= '0;
            bg_p1_q    <= '0;
            blank_p1_q <= 1'b0;
            pix_p2_q   <= '0;
            acc_q      <= 1'b0;
            collide_q  <= 1'b0;
        end else begin
            flash_q <= flash_d;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                flashing_q[i] <= (flash_d[i] != '0);
                // Odd counter value implies nonzero: flash phase is simply bit 0.
                white_p1_q[i] <= flash_q[i][0];
            end
            // stage 1
            on_p1_q    <= on_d;
            rgb_p1_q   <= sprite_rgb;
            bg_p1_q    <= {bg_red, bg_green, bg_blue};
            blank_p1_q <= blank;
            // stage 2
            pix_p2_q   <= pix_d;
            acc_q      <= acc_d;
            collide_q  <= collide_d;
        end
    end

    assign Red           = pix_p2_q[3*COLOR_W-1 -: COLOR_W];
    assign Green         = pix_p2_q[2*COLOR_W-1 -: COLOR_W];
    assign Blue          = pix_p2_q[COLOR_W-1:0];
    assign collide_frame = collide_q;
    assign flashing      = flashing_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed scenarios plus random traffic, all checked
// every cycle against a frame/pixel-level behavioural model.
module tb_sprite_compositor;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fs      = 1'b0;
    logic [9:0]  dx = '0, dy = '0;
    logic        blk = 1'b1;
    logic [9:0]  spx [2];
    logic [9:0]  spy [2];
    logic [1:0]  en = '0;
    logic [11:0] col [2];
    logic [1:0]  hitv = '0;
    logic [11:0] bg = '0;

    logic [3:0]  Red, Green, Blue;
    logic        collide_frame;
    logic [1:0]  flashing;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int          mF [2];
    bit          mAcc, mCol, mPrevOv;
    logic [11:0] mE1, mE2;

    always #5 vga_clk = ~vga_clk;

    sprite_compositor dut (
        .vga_clk      (vga_clk),
        .reset_n      (reset_n),
        .frame_start  (fs),
        .DrawX        (dx),
        .DrawY        (dy),
        .blank        (blk),
        .sprite_x     ({spx[1], spx[0]}),
        .sprite_y     ({spy[1], spy[0]}),
        .sprite_en    (en),
        .sprite_rgb   ({col[1], col[0]}),
        .hit          (hitv),
        .bg_red       (bg[11:8]),
        .bg_green     (bg[7:4]),
        .bg_blue      (bg[3:0]),
        .Red          (Red),
        .Green        (Green),
        .Blue         (Blue),
        .collide_frame(collide_frame),
        .flashing     (flashing)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit on_m(int i);
        int x, y, sx, sy;
        x  = int'(dx);
        y  = int'(dy);
        sx = int'(spx[i]);
        sy = int'(spy[i]);
        return en[i] && x >= sx && x < sx + 120 && y >= sy && y < sy + 180;
    endfunction

    function automatic logic [11:0] pix_exp();
        if (!blk) return 12'h000;
        for (int i = 0; i < 2; i++)
            if (on_m(i)) return (mF[i] % 2 == 1) ? 12'hFFF : col[i];
        return bg;
    endfunction

    task automatic model_reset();
        mF[0] = 0; mF[1] = 0;
        mAcc = 0; mCol = 0; mPrevOv = 0;
        mE1 = '0; mE2 = '0;
    endtask

    // One pixel clock: advance the model on the edge, then compare just after it.
    task automatic cycle();
        logic [11:0] e;
        bit ov;
        @(posedge vga_clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            e  = pix_exp();
            ov = blk && on_m(0) && on_m(1);
            if (fs) begin
                mCol = mAcc;
                mAcc = mPrevOv;
            end else begin
                mAcc = mAcc | mPrevOv;
            end
            for (int i = 0; i < 2; i++) begin
                if (hitv[i]) mF[i] = 8;
                else if (fs && mF[i] > 0) mF[i] = mF[i] - 1;
            end
            mE2 = mE1;
            mE1 = e;
            mPrevOv = ov;
        end
        #1;
        fs   = 1'b0;
        hitv = '0;
        check_eq("rgb",      {Red, Green, Blue}, mE2);
        check_eq("collide",  collide_frame, mCol);
        check_eq("flashing", flashing, {mF[1] != 0, mF[0] != 0});
    endtask

    task automatic pix(input int x, input int y, input logic b);
        dx  = x[9:0];
        dy  = y[9:0];
        blk = b;
        cycle();
    endtask

    task automatic pix_expect(input string tag, input int x, input int y, input logic [11:0] exp);
        pix(x, y, 1'b1);
        pix(x, y, 1'b1);
        check_eq(tag, {Red, Green, Blue}, exp);
    endtask

    task automatic frame_pulse();
        fs = 1'b1;
        pix(600, 600, 1'b1);
    endtask

    initial begin
        int cnt;
        model_reset();
        spx[0] = 10'd100; spy[0] = 10'd50; col[0] = 12'h0F0;
        spx[1] = 10'd150; spy[1] = 10'd60; col[1] = 12'hF00;

        // Reset release, background passthrough with 2-cycle latency
        bg = 12'h357; en = '0; blk = 1'b1;
        cycle(); cycle();
        check_eq("reset_rgb", {Red, Green, Blue}, 12'h000);
        check_eq("reset_flash", flashing, 2'b00);
        reset_n = 1'b1;
        pix(10, 10, 1'b1);
        check_eq("lat1_rgb", {Red, Green, Blue}, 12'h000);
        pix(10, 10, 1'b1);
        check_eq("lat2_rgb", {Red, Green, Blue}, 12'h357);

        // Priority and sprite extents
        en = 2'b11;
        pix_expect("prio_160", 160, 70, 12'h0F0);
        pix_expect("prio_219", 219, 70, 12'h0F0);
        pix_expect("s1_220",   220, 70, 12'hF00);
        pix_expect("bg_270",   270, 70, 12'h357);

        // Collision per frame
        pix(160, 70, 1'b1);
        pix(600, 600, 1'b1);
        frame_pulse();
        check_eq("collide_set", collide_frame, 1'b1);
        en = 2'b01;
        pix(160, 70, 1'b1);
        pix(600, 600, 1'b1);
        frame_pulse();
        check_eq("collide_clr", collide_frame, 1'b0);
        en = 2'b11;
        pix(160, 70, 1'b0);
        pix(600, 600, 1'b1);
        frame_pulse();
        check_eq("collide_blank", collide_frame, 1'b0);

        // No horizontal wrap
        en = 2'b01; spx[0] = 10'd1000;
        pix_expect("edge_1023", 1023, 70, 12'h0F0);
        pix_expect("nowrap_0",  0,    70, 12'h357);
        pix_expect("nowrap_119", 119, 70, 12'h357);
        spx[0] = 10'd100;

        // Flash sequence: 8 frames, white on odd counts
        hitv = 2'b01;
        pix(600, 600, 1'b1);
        check_eq("flash_on", flashing[0], 1'b1);
        for (int k = 0; k < 8; k++) begin
            pix_expect("flash_col", 160, 70, ((8 - k) % 2 == 1) ? 12'hFFF : 12'h0F0);
            frame_pulse();
        end
        check_eq("flash_done", flashing[0], 1'b0);

        // Hit coincident with frame_start reloads to full count
        hitv = 2'b01;
        frame_pulse();
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (flashing[0]) begin
                frame_pulse();
                cnt++;
            end
        end
        check_eq("hit_on_fs_len", cnt, 8);

        // Async reset mid-frame with live flash and collision state
        hitv = 2'b01;
        pix(600, 600, 1'b1);
        frame_pulse(); frame_pulse(); frame_pulse();
        en = 2'b11;
        pix(160, 70, 1'b1);
        pix(160, 70, 1'b1);
        check_eq("pre_rst_flash", flashing[0], 1'b1);
        #3 reset_n = 1'b0;
        #1;
        check_eq("rst_rgb",     {Red, Green, Blue}, 12'h000);
        check_eq("rst_collide", collide_frame, 1'b0);
        check_eq("rst_flash",   flashing, 2'b00);
        cycle(); cycle();
        reset_n = 1'b1;
        pix(600, 600, 1'b1);
        frame_pulse();
        check_eq("post_rst_collide", collide_frame, 1'b0);
        check_eq("post_rst_flash",   flashing, 2'b00);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                spx[0] = 10'($urandom);
                spy[0] = 10'($urandom);
                spx[1] = spx[0] + 10'($urandom_range(0, 200));
                spy[1] = spy[0] + 10'($urandom_range(0, 250));
                col[0] = 12'($urandom);
                col[1] = 12'($urandom);
                en     = 2'($urandom);
            end
            bg   = 12'($urandom);
            fs   = ($urandom_range(0, 15) == 0);
            hitv = {($urandom_range(0, 31) == 0), ($urandom_range(0, 31) == 0)};
            dx   = spx[0] + 10'($urandom_range(0, 320));
            dy   = spy[0] + 10'($urandom_range(0, 420));
            blk  = ($urandom_range(0, 7) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
